// File: rtl/ubcd_display_scanner.sv
// ubcd_display_scanner: time-multiplexed scan of DIGITS digits through one shared BCD-to-7-segment decoder
//   clk, rst_n        clock, asynchronous active-low reset
//   en                scan enable; low parks in IDLE with every digit off
//   digits            packed BCD, nibble i drives digit i (DIGITS-1 most significant)
//   zsup, lt_req      leading-zero suppression and lamp test, latched once per frame
//   al                decoder output polarity, passed straight through
//   bright            PWM brightness, 0 dark .. 15 full, used live
//   dec_value/rbi/bi/lt/al  shared decoder inputs; dec_rbo, dec_seg its outputs
//   seg_out, dig_sel  registered segment drive and one-hot digit enable
//   frame_start       one-clock pulse as the most significant digit's slot begins
module ubcd_display_scanner #(
  parameter int DIGITS = 4,
  parameter int DWELL = 1024,
  parameter int BLANK = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [4*DIGITS-1:0] digits,
  input  logic                zsup,
  input  logic                lt_req,
  input  logic                al,
  input  logic [3:0]          bright,
  output logic [3:0]          dec_value,
  output logic                dec_rbi,
  output logic                dec_bi,
  output logic                dec_lt,
  output logic                dec_al,
  input  logic                dec_rbo,
  input  logic [6:0]          dec_seg,
  output logic [6:0]          seg_out,
  output logic [DIGITS-1:0]   dig_sel,
  output logic                frame_start
);
  localparam int CW = $clog2(DWELL);
  localparam int IW = $clog2(DIGITS);
  localparam logic [IW-1:0] TOP = IW'(DIGITS - 1);
  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic frame_nxt, lt_sh, rb_chain, lit;
  logic [4*DIGITS-1:0] dig_sh;
  logic [6:0] seg_n;
  logic [3:0] pwm;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      idx <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      idx <= idx_nxt;
    end
  // the slot counter runs across the whole slot, so SHOW starts at cnt == BLANK
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt + CW'(1);
    idx_nxt = idx;
    if (!en) begin
      state_nxt = S_IDLE;
      cnt_nxt = '0;
      idx_nxt = '0;
    end else if (state == S_IDLE) begin
      state_nxt = S_BLANK;
      cnt_nxt = '0;
      idx_nxt = TOP;
    end else if (state == S_BLANK && cnt == CW'(BLANK - 1)) begin
      state_nxt = S_SHOW;
    end else if (state == S_SHOW && cnt == CW'(DWELL - 1)) begin
      state_nxt = S_BLANK;
      cnt_nxt = '0;
      idx_nxt = (idx == '0) ? TOP : idx - IW'(1);
    end
  end
  always_comb begin
    dec_bi = state != S_IDLE;
    dec_rbi = (idx == '0) || rb_chain;
    dec_value = 4'(dig_sh >> {idx, 2'b00});
    dec_lt = ~lt_sh;
    dec_al = al;
  end
  assign frame_nxt = en && state_nxt == S_BLANK && cnt_nxt == '0 && idx_nxt == TOP;
  assign pwm = 4'(cnt - CW'(BLANK));
  assign lit = bright == 4'hF || pwm < bright;
  // segments are held polarity-normalised so the reset value is a constant that still reads as all-off
  assign seg_out = seg_n ^ {7{~al}};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dig_sh <= '0;
      lt_sh <= 1'b0;
      rb_chain <= 1'b1;
      frame_start <= 1'b0;
      seg_n <= '0;
      dig_sel <= '0;
    end else begin
      frame_start <= frame_nxt;
      if (frame_nxt) begin
        dig_sh <= digits;
        lt_sh <= lt_req;
      end
      rb_chain <= frame_nxt ? ~zsup : (state == S_BLANK && cnt == CW'(BLANK - 1)) ? dec_rbo : rb_chain;
      seg_n <= dec_seg ^ {7{~al}};
      dig_sel <= (en && state == S_SHOW && lit) ? DIGITS'(1) << idx : '0;
    end
endmodule

// File: tb/tb_ubcd_display_scanner.sv
// tb_ubcd_display_scanner: directed bench for the scanner driving a behavioural BCD decoder model
module tb_ubcd_display_scanner;
  localparam int DIGITS = 4, DWELL = 32, BLANK = 2;
  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
  logic clk = 1'b0, rst_n = 1'b1, en = 1'b0, zsup = 1'b0, lt_req = 1'b0, al = 1'b1;
  logic [15:0] digits = 16'h0;
  logic [3:0] bright = 4'hF;
  logic [3:0] dec_value;
  logic dec_rbi, dec_bi, dec_lt, dec_al, dec_rbo, frame_start, zero_blank;
  logic [6:0] dec_seg, seg_out, seg_hi;
  logic [DIGITS-1:0] dig_sel;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  ubcd_display_scanner #(.DIGITS(DIGITS), .DWELL(DWELL), .BLANK(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .zsup(zsup), .lt_req(lt_req),
    .al(al), .bright(bright), .dec_value(dec_value), .dec_rbi(dec_rbi), .dec_bi(dec_bi),
    .dec_lt(dec_lt), .dec_al(dec_al), .dec_rbo(dec_rbo), .dec_seg(dec_seg),
    .seg_out(seg_out), .dig_sel(dig_sel), .frame_start(frame_start)
  );
  // decoder: BI blanks first, then lamp test, then ripple-blanked zero, else the digit pattern
  assign zero_blank = !dec_rbi && dec_value == 4'd0 && dec_lt;
  assign dec_rbo = !zero_blank;
  assign seg_hi = (!dec_bi || zero_blank) ? 7'h00 : !dec_lt ? 7'h7F : SEG[dec_value];
  assign dec_seg = dec_al ? seg_hi : ~seg_hi;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // called on the negedge where frame_start is high; walks the whole frame
  task automatic run_frame(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                           input logic [6:0] e1, input logic [6:0] e0, input int br);
    logic [6:0] e [4];
    e = '{e0, e1, e2, e3};
    for (int j = 1; j <= 4 * DWELL; j++) begin
      int r, s, pp;
      logic on;
      @(negedge clk);
      r = j - 1;
      s = r / DWELL;
      pp = r % DWELL;
      on = pp >= BLANK && (br == 15 || ((pp - BLANK) % 16) < br);
      chk({tag, "_sel"}, 16'(dig_sel), on ? 16'(8 >> s) : 16'h0);
      chk({tag, "_fs"}, 16'(frame_start), 16'(j == 4 * DWELL));
      if (pp >= BLANK) chk({tag, "_seg"}, 16'(seg_out), 16'(e[3 - s]));
    end
  endtask
  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_seg", 16'(seg_out), 16'h0);
    chk("rst_sel", 16'(dig_sel), 16'h0);
    chk("rst_fs", 16'(frame_start), 16'h0);
    chk("rst_bi", 16'(dec_bi), 16'h0);
    chk("rst_rbi", 16'(dec_rbi), 16'h1);
    chk("rst_lt", 16'(dec_lt), 16'h1);
    chk("rst_val", 16'(dec_value), 16'h0);
    rst_n = 1'b1;
    en = 1'b1;
    digits = 16'h1234;
    @(negedge clk);
    chk("fs_first", 16'(frame_start), 16'h1);
    chk("val_top", 16'(dec_value), 16'h1);
    digits = 16'h0042;
    zsup = 1'b1;
    run_frame("f1", 7'h06, 7'h5B, 7'h4F, 7'h66, 15);
    zsup = 1'b0;
    run_frame("f2", 7'h00, 7'h00, 7'h66, 7'h5B, 15);
    digits = 16'h0000;
    zsup = 1'b1;
    run_frame("f3", 7'h3F, 7'h3F, 7'h66, 7'h5B, 15);
    bright = 4'd4;
    run_frame("f4", 7'h00, 7'h00, 7'h00, 7'h3F, 4);
    bright = 4'd0;
    lt_req = 1'b1;
    run_frame("f5", 7'h00, 7'h00, 7'h00, 7'h3F, 0);
    bright = 4'hF;
    run_frame("f6", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 15);
    al = 1'b0;
    #1 chk("al_pass", 16'(dec_al), 16'h0);
    run_frame("f7", 7'h00, 7'h00, 7'h00, 7'h00, 15);
    al = 1'b1;
    lt_req = 1'b0;
    digits = 16'h1234;
    zsup = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_drop_sel", 16'(dig_sel), 16'h8);
    chk("pre_drop_seg", 16'(seg_out), 16'h7F);
    en = 1'b0;
    @(negedge clk);
    chk("drop_sel", 16'(dig_sel), 16'h0);
    chk("drop_bi", 16'(dec_bi), 16'h0);
    repeat (3) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("reen_fs", 16'(frame_start), 16'h1);
    chk("reen_lt", 16'(dec_lt), 16'h1);
    chk("reen_val", 16'(dec_value), 16'h1);
    repeat (10) @(negedge clk);
    chk("mid_sel", 16'(dig_sel), 16'h8);
    chk("mid_seg", 16'(seg_out), 16'h06);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg", 16'(seg_out), 16'h0);
    chk("arst_sel", 16'(dig_sel), 16'h0);
    chk("arst_bi", 16'(dec_bi), 16'h0);
    chk("arst_fs", 16'(frame_start), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_fs", 16'(frame_start), 16'h1);
    run_frame("f9", 7'h06, 7'h5B, 7'h4F, 7'h66, 15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
